// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multi-cycle RV32I datapath
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [2:0]  imm_src,
    output logic        illegal,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_JALRWB   = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_ILLEGAL  = 4'd14;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7b5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    logic is_load, is_store, is_rtype, is_itype, is_branch, is_jal, is_jalr, is_lui;
    logic bad_funct3;

    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_rtype  = (opcode == 7'b0110011);
    assign is_itype  = (opcode == 7'b0010011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_lui    = (opcode == 7'b0110111);

    // Shifts, unsupported branch compares and non-word memory accesses are trapped in DECODE.
    assign bad_funct3 = ((is_rtype || is_itype) && (funct3 == 3'b001 || funct3 == 3'b101))
                     || (is_branch && !(funct3 == 3'b000 || funct3 == 3'b001 ||
                                        funct3 == 3'b100 || funct3 == 3'b101))
                     || ((is_load || is_store) && funct3 != 3'b010);

    function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_from_funct3 = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_from_funct3 = ALU_AND;
            3'b110:  alu_from_funct3 = ALU_OR;
            3'b100:  alu_from_funct3 = ALU_XOR;
            3'b010:  alu_from_funct3 = ALU_SLT;
            3'b011:  alu_from_funct3 = ALU_SLTU;
            default: alu_from_funct3 = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        imm_src = 3'b000;
        if (is_store)       imm_src = 3'b001;
        else if (is_branch) imm_src = 3'b010;
        else if (is_jal)    imm_src = 3'b011;
        else if (is_lui)    imm_src = 3'b100;
    end

    logic pc_write_s, mem_write_s, ir_write_s, reg_write_s, branch_taken;

    // blt/bge use slt, so a nonzero (less-than) result means zero=0.
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = !zero;
            3'b101:  branch_taken = zero;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        state_d     = S_FETCH;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (bad_funct3)                state_d = S_ILLEGAL;
                else if (is_load || is_store)  state_d = S_MEMADR;
                else if (is_rtype)             state_d = S_EXECR;
                else if (is_itype)             state_d = S_EXECI;
                else if (is_branch)            state_d = S_BRANCH;
                else if (is_jal)               state_d = S_JAL;
                else if (is_jalr)              state_d = S_JALR;
                else if (is_lui)               state_d = S_LUI;
                else                           state_d = S_ILLEGAL;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = is_load ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_from_funct3(funct3, funct7b5);
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_from_funct3(funct3, 1'b0);
                state_d     = S_ALUWB;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = funct3[2] ? ALU_SLT : ALU_SUB;
                pc_write_s  = branch_taken;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_JALRWB;
            end
            S_JALRWB: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                reg_write_s = 1'b1;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            default: state_d = S_ILLEGAL;
        endcase
    end

    // Reset suppresses every write in the cycle it is asserted, so an abandoned instruction never half-commits.
    assign pc_write  = pc_write_s  & ~rst;
    assign mem_write = mem_write_s & ~rst;
    assign ir_write  = ir_write_s  & ~rst;
    assign reg_write = reg_write_s & ~rst;
    assign illegal   = (state_q == S_ILLEGAL) & ~rst;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven and randomized bench for multicycle_controller
module tb_multicycle_controller;

    logic        clk, rst, zero;
    logic [31:0] instr;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  alu_control, imm_src;
    logic [3:0]  state;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [2:0] imm;
    } outs_t;

    typedef struct {
        logic [31:0] i;
        logic        z;
        int          cycles;
    } vec_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4,
                   K_JAL = 5, K_JALR = 6, K_LUI = 7, K_BAD = 8;

    int checks = 0;
    int failures = 0;

    outs_t act;
    assign act = '{st: state, ill: illegal, pcw: pc_write, adr: adr_src, memw: mem_write,
                   irw: ir_write, regw: reg_write, res: result_src, a: alu_src_a,
                   b: alu_src_b, alu: alu_control, imm: imm_src};

    function automatic int classify(input logic [31:0] i);
        logic [2:0] f3 = i[14:12];
        case (i[6:0])
            7'h03:   return (f3 == 3'd2) ? K_LW : K_BAD;
            7'h23:   return (f3 == 3'd2) ? K_SW : K_BAD;
            7'h33:   return (f3 == 3'd1 || f3 == 3'd5) ? K_BAD : K_R;
            7'h13:   return (f3 == 3'd1 || f3 == 3'd5) ? K_BAD : K_I;
            7'h63:   return (f3 inside {3'd0, 3'd1, 3'd4, 3'd5}) ? K_BR : K_BAD;
            7'h6F:   return K_JAL;
            7'h67:   return K_JALR;
            7'h37:   return K_LUI;
            default: return K_BAD;
        endcase
    endfunction

    function automatic int cpi(input int kind);
        case (kind)
            K_LW:    return 5;
            K_BR:    return 3;
            K_BAD:   return 0;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] opc);
        case (opc)
            7'h23:   return 3'd1;
            7'h63:   return 3'd2;
            7'h6F:   return 3'd3;
            7'h37:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] arith_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 3'd1 : 3'd0;
            3'd7:    return 3'd2;
            3'd6:    return 3'd3;
            3'd4:    return 3'd4;
            3'd2:    return 3'd5;
            3'd3:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs at cycle k of one instruction (k=0 is its fetch cycle).
    function automatic outs_t model(input logic [31:0] i, input logic z, input int k);
        outs_t o;
        int c = classify(i);
        logic [2:0] f3 = i[14:12];
        o = '0;
        o.imm = imm_of(i[6:0]);
        if (k == 0) begin
            o.irw = 1; o.pcw = 1; o.b = 2; o.res = 2;
        end else if (k == 1) begin
            o.st = 1; o.a = 1; o.b = 1;
        end else if (c == K_BAD) begin
            o.st = 14; o.ill = 1;
        end else if (k == 2) begin
            case (c)
                K_LW, K_SW: begin o.st = 2; o.a = 2; o.b = 1; end
                K_R:    begin o.st = 6; o.a = 2; o.alu = arith_op(f3, i[30]); end
                K_I:    begin o.st = 7; o.a = 2; o.b = 1; o.alu = arith_op(f3, 1'b0); end
                K_BR: begin
                    o.st = 9; o.a = 2;
                    o.alu = (f3 >= 3'd4) ? 3'd5 : 3'd1;
                    o.pcw = ((f3 == 3'd1) || (f3 == 3'd4)) ? !z : z;
                end
                K_JAL:  begin o.st = 10; o.a = 1; o.b = 2; o.pcw = 1; end
                K_JALR: begin o.st = 11; o.a = 2; o.b = 1; o.res = 2; o.pcw = 1; end
                default: begin o.st = 13; o.a = 3; o.b = 1; end
            endcase
        end else if (k == 3) begin
            case (c)
                K_LW:   begin o.st = 3; o.adr = 1; end
                K_SW:   begin o.st = 5; o.adr = 1; o.memw = 1; end
                K_JALR: begin o.st = 12; o.a = 1; o.b = 2; o.res = 2; o.regw = 1; end
                default: begin o.st = 8; o.regw = 1; end
            endcase
        end else begin
            o.st = 4; o.res = 1; o.regw = 1;
        end
        return o;
    endfunction

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, a, e);
        end
    endtask

    // Entered just after a posedge; returns just after the posedge that starts the next fetch (or after maxk cycles).
    task automatic run_instr(input logic [31:0] i, input logic z, input int maxk, output int measured);
        outs_t e;
        instr = i; zero = z; measured = 0;
        for (int k = 0; k < maxk; k++) begin
            @(negedge clk);
            e = model(i, z, k);
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL step instr=%h k=%0d act=%h exp=%h", i, k, act, e);
            end
            @(posedge clk); #1;
            if (state == 4'd0) begin
                measured = k + 1;
                break;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_int("reset_enables", {pc_write, ir_write, mem_write, reg_write, illegal}, 0);
            @(posedge clk); #1;
            check_int("reset_state", state, 0);
        end
        rst = 0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] base = $urandom;
        logic [2:0]  f3;
        logic [6:0]  opc;
        int          r = $urandom_range(0, 11);
        case (r)
            0: begin opc = 7'h03; f3 = 3'd2; end
            1: begin opc = 7'h23; f3 = 3'd2; end
            2, 3: begin
                opc = (r == 2) ? 7'h33 : 7'h13;
                f3 = 3'($urandom_range(0, 7));
                if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
            end
            4, 5: begin
                opc = 7'h63;
                f3 = 3'($urandom_range(0, 3));
                if (f3 >= 3'd2) f3 = f3 + 3'd2;
            end
            6: begin opc = 7'h6F; f3 = base[14:12]; end
            7: begin opc = 7'h67; f3 = base[14:12]; end
            8: begin opc = 7'h37; f3 = base[14:12]; end
            9: begin opc = 7'h13; f3 = base[12] ? 3'd1 : 3'd5; end
            10: begin opc = 7'h63; f3 = 3'($urandom_range(2, 3)); f3[2] = base[13]; end
            default: begin opc = base[6:0]; f3 = base[14:12]; end
        endcase
        return {base[31:15], f3, base[11:7], opc};
    endfunction

    vec_t vecs[12];

    initial begin
        int m;
        logic [31:0] ri;
        logic        rz;
        vecs[0]  = '{32'h0080A283, 1'b0, 5};
        vecs[1]  = '{32'h0050A423, 1'b0, 4};
        vecs[2]  = '{32'h402081B3, 1'b0, 4};
        vecs[3]  = '{32'h00500093, 1'b0, 4};
        vecs[4]  = '{32'h008000EF, 1'b0, 4};
        vecs[5]  = '{32'h000100E7, 1'b0, 4};
        vecs[6]  = '{32'h123452B7, 1'b0, 4};
        vecs[7]  = '{32'h00208463, 1'b1, 3};
        vecs[8]  = '{32'h00209463, 1'b1, 3};
        vecs[9]  = '{32'h0020C463, 1'b0, 3};
        vecs[10] = '{32'h0000007F, 1'b0, 0};
        vecs[11] = '{32'h00109093, 1'b0, 0};

        instr = 32'h0; zero = 0; rst = 1;
        do_reset(2);

        for (int v = 0; v < 12; v++) begin
            run_instr(vecs[v].i, vecs[v].z, 12, m);
            check_int("table_cycles", m, vecs[v].cycles);
            if (vecs[v].cycles == 0) do_reset(1);
        end

        // Reset held through MEMREAD, then during MEMWB and MEMWRITE: no write may leak out.
        run_instr(32'h0080A283, 1'b0, 3, m);
        check_int("in_memread", state, 3);
        do_reset(3);
        run_instr(32'h0080A283, 1'b0, 4, m);
        check_int("in_memwb", state, 4);
        do_reset(1);
        run_instr(32'h0050A423, 1'b0, 3, m);
        check_int("in_memwrite", state, 5);
        do_reset(1);
        run_instr(32'h402081B3, 1'b0, 8, m);
        check_int("after_reset_cycles", m, 4);

        for (int n = 0; n < 300; n++) begin
            ri = gen_instr();
            rz = 1'($urandom);
            if (classify(ri) == K_BAD) begin
                run_instr(ri, rz, 5, m);
                check_int("rand_cycles", m, 0);
                do_reset(1);
            end else begin
                run_instr(ri, rz, 8, m);
                check_int("rand_cycles", m, cpi(classify(ri)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
